// File: rtl/fb_pkg.sv
// Shared framebuffer geometry, colour layout and painter FSM encoding.
package fb_pkg;

  localparam int FB_W  = 8;
  localparam int FB_H  = 8;
  localparam int FB_AW = 6;
  localparam int FB_CW = 9;

  // Position of each 3-bit colour channel within a memory word.
  localparam int R_LSB = 6;
  localparam int G_LSB = 3;
  localparam int B_LSB = 0;

  localparam int XY_W = $clog2(FB_W);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_CLEAR = 2'd2
  } fb_state_t;

  // Cell address as seen by the scan-out read side: x in the upper field.
  function automatic logic [FB_AW-1:0] cell_addr(input logic [XY_W-1:0] x,
                                                 input logic [XY_W-1:0] y);
    return {x, y};
  endfunction

endpackage

// File: rtl/fb_painter_if.sv
// Framebuffer memory write port.
interface fb_painter_if;
  import fb_pkg::*;

  logic             we;
  logic [FB_AW-1:0] wa;
  logic [FB_CW-1:0] wv;

  modport master (output we, wa, wv);
  modport slave  (input  we, wa, wv);

endinterface

// File: rtl/key_debounce.sv
// Debounces one raw active-low key and emits a one-cycle pulse per press.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] TC = CW'(DEBOUNCE_CYCLES);

  logic          sync1;
  logic          sync2;
  logic          stable;
  logic [CW-1:0] cnt;

  // Synchronise, count persistent disagreement, flip stable at terminal count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1  <= 1'b1;
      sync2  <= 1'b1;
      stable <= 1'b1;
      cnt    <= '0;
      press  <= 1'b0;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (cnt == TC) begin
        stable <= sync2;
        cnt    <= '0;
        press  <= ~sync2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/fb_painter.sv
// Key-driven cursor and writer for the 8x8 framebuffer.
//
// state    | meaning
// ---------+---------------------------------------------------------
// ST_IDLE  | waiting for key pulses; moves, starts a write or a clear
// ST_WRITE | single write cycle on the memory port (we high)
// ST_CLEAR | 64-cycle sweep writing the latched colour to every cell
module fb_painter
  import fb_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       key_n,
  input  logic [FB_CW-1:0] color,
  fb_painter_if.master     wr,
  output logic [FB_AW-1:0] cursor,
  output logic             busy
);

  logic [3:0] press;

  for (genvar k = 0; k < 4; k++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key (
      .clk   (clk),
      .rst   (rst),
      .key_n (key_n[k]),
      .press (press[k])
    );
  end

  fb_state_t        state_q, state_d;
  logic [XY_W-1:0]  cur_x, cur_y, cur_x_d, cur_y_d;
  logic             we_d, busy_d, move_ok;
  logic [FB_AW-1:0] wa_d;
  logic [FB_CW-1:0] wv_d;

  assign cursor = cell_addr(cur_x, cur_y);

  // Next-state and next-output decode; wa doubles as the sweep counter.
  always_comb begin
    state_d = state_q;
    we_d    = 1'b0;
    busy_d  = 1'b0;
    wa_d    = wr.wa;
    wv_d    = wr.wv;
    cur_x_d = cur_x;
    cur_y_d = cur_y;
    move_ok = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (press[3]) begin
          state_d = ST_CLEAR;
          we_d    = 1'b1;
          busy_d  = 1'b1;
          wa_d    = '0;
          wv_d    = color;
        end else begin
          move_ok = 1'b1;
          if (press[0]) begin
            state_d = ST_WRITE;
            we_d    = 1'b1;
            wa_d    = cell_addr(cur_x, cur_y);
            wv_d    = color;
          end
        end
      end
      ST_WRITE: begin
        move_ok = 1'b1;
        state_d = ST_IDLE;
      end
      ST_CLEAR: begin
        if (wr.wa == FB_AW'(FB_W * FB_H - 1)) begin
          state_d = ST_IDLE;
        end else begin
          we_d   = 1'b1;
          busy_d = 1'b1;
          wa_d   = wr.wa + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (move_ok) begin
      if (press[1]) cur_x_d = cur_x + 1'b1;
      if (press[2]) cur_y_d = cur_y + 1'b1;
    end
  end

  // State, cursor and registered memory-port outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cur_x   <= '0;
      cur_y   <= '0;
      wr.we   <= 1'b0;
      wr.wa   <= '0;
      wr.wv   <= '0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_x   <= cur_x_d;
      cur_y   <= cur_y_d;
      wr.we   <= we_d;
      wr.wa   <= wa_d;
      wr.wv   <= wv_d;
      busy    <= busy_d;
    end
  end

endmodule
